prog_mem_loader: RTL and testbench
==================================

# prog_mem_loader

In-system program loader and port controller for the 256x16 PacoBlaze instruction RAM. It owns the RAM's address/data/write-enable pins and shares them between the processor fetch address and a byte-stream loader, typically fed by a UART receiver. On a start command it holds the processor in reset and writes a word count, program words and a checksum into the RAM. It then releases the processor on success, or keeps it in reset and flags an error.

## Interface
- START_BYTE, 8'h5A, command byte that begins a load when seen in RUN
- TIMEOUT, 1000000, max idle cycles between accepted bytes during a load (>=2)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid; a byte transfers when rx_valid && rx_ready
- rx_ready  out  1  loader can accept a byte this cycle
- cpu_address  in  8  processor fetch address
- ram_address  out  8  to RAM ADDR
- ram_di  out  16  to RAM DI
- ram_we  out  1  to RAM WE (RAM EN tied high externally)
- cpu_reset  out  1  active-high reset to the processor
- load_busy  out  1  high from START_BYTE accept until DONE/ERR exit
- load_ok  out  1  one-cycle pulse on successful load
- load_err  out  1  sticky error; cleared on next START_BYTE accept or reset

## Operation
- States: RUN, COUNT, HI, LO, WRITE, CHECK, ERR.
- RUN:
  - rx_ready=1; bytes other than START_BYTE are consumed and ignored.
  - START_BYTE -> COUNT; set cpu_reset, load_busy; clear load_err, checksum accumulator, word address.
- COUNT: accept byte n; words = n+1 (1..256); accumulator += n; -> HI.
- HI: accept byte, latch as ram_di[15:8]; accumulator += byte; -> LO.
- LO: accept byte, latch as ram_di[7:0]; accumulator += byte; -> WRITE.
- WRITE:
  - rx_ready=0; ram_we=1 for exactly this cycle at ram_address = word address.
  - If word address == n -> CHECK, else word address+1 -> HI.
  - Word address is 8-bit and never wraps within a load (max 255).
- CHECK: accept checksum byte c.
  - (accumulator + c) mod 256 == 0 -> RUN; cpu_reset=0, load_busy=0, load_ok pulse.
  - Otherwise -> ERR.
- ERR:
  - load_err=1, cpu_reset stays 1, load_busy=0, rx_ready=1.
  - START_BYTE -> COUNT (new load); other bytes ignored.
  - The processor is never released with a partially loaded or corrupt image.
- Timeout:
  - In COUNT/HI/LO/CHECK, an idle counter increments each cycle with no transfer and resets on each transfer.
  - Reaching TIMEOUT -> ERR.
  - WRITE is never interrupted.
- Address mux: ram_address = cpu_address (combinational) when load_busy=0, else the registered word address. ram_we=0 outside WRITE.
- Accumulator is 8-bit, modulo 256. It covers the count byte, all data bytes and the checksum, but not START_BYTE.

## Timing
- Reset values: state=RUN, cpu_reset=0, load_busy=0, load_ok=0, load_err=0, ram_we=0, ram_di=0, rx_ready=1, counters=0.
- Reset mid-load returns to RUN with cpu_reset=0 and abandons the load; RAM contents are undefined.
- Byte accept is single-cycle; rx_ready and state are registered. Max throughput is 1 byte/cycle except a 1-cycle stall (rx_ready=0) after each low byte.
- cpu_reset rises the cycle after START_BYTE is accepted.
- cpu_reset falls, and load_ok pulses, the cycle after the checksum byte is accepted.
- RAM write occurs the cycle after the low byte is accepted. With synchronous-read RAM, the first fetch after release returns the word at cpu_address.
- load_err asserts the cycle after the bad checksum byte or the timeout cycle.

## Test plan
- Good load:
  - Stimulus: 5A,01,0A,00,02,AA,49 back-to-back.
  - RAM[0]=0A00 and RAM[1]=02AA written with one ram_we cycle each.
  - rx_ready low one cycle after each low byte.
  - load_ok single pulse; cpu_reset low afterward; ram_address tracks cpu_address.
- Bad checksum: same stream with final byte 48 -> load_err=1, cpu_reset stays 1, no load_ok; then a correct full stream clears load_err and releases the CPU.
- Full 256-word load: count FF, 512 data bytes with data = address, correct checksum -> 256 writes at addresses 00..FF with no wrap; load_ok.
- Timeout: 5A,01,0A then TIMEOUT idle cycles -> ERR, load_err=1, cpu_reset=1; TIMEOUT-1 idle cycles followed by a byte does not error.
- Noise in RUN: bytes 00,FF,A5 with rx_valid toggling -> no state change, cpu_reset=0, ram_we never asserted.
- Reset mid-load: reset_n low during HI for 1 cycle -> all outputs at reset values next cycle; a following byte 01 is ignored.

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: byte-stream loader for the 256x16 instruction RAM that holds the CPU in reset while loading
module prog_mem_loader #(
    parameter logic [7:0] START_BYTE = 8'h5A,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  cpu_address,
    output logic [7:0]  ram_address,
    output logic [15:0] ram_di,
    output logic        ram_we,
    output logic        cpu_reset,
    output logic        load_busy,
    output logic        load_ok,
    output logic        load_err
);
    localparam int IW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {RUN, COUNT, HI, LO, WRITE, CHECK, ERR} state_t;
    state_t state, state_n;
    logic [7:0] words, addr, acc, sum;
    logic [IW-1:0] idle;
    logic xfer, start, waiting, timeout;
    always_comb begin
        rx_ready    = state != WRITE;
        ram_we      = state == WRITE;
        cpu_reset   = state != RUN;
        load_err    = state == ERR;
        load_busy   = !(state == RUN || state == ERR);
        ram_address = load_busy ? addr : cpu_address;
        xfer        = rx_valid && rx_ready;
        start       = xfer && rx_data == START_BYTE && (state == RUN || state == ERR);
        waiting     = state inside {COUNT, HI, LO, CHECK};
        timeout     = idle == IW'(TIMEOUT - 1);
        sum         = acc + rx_data;
    end
    // A transfer always wins over a timeout that expires in the same cycle
    always_comb begin
        state_n = state;
        case (state)
            RUN, ERR: state_n = start ? COUNT : state;
            COUNT:    state_n = xfer ? HI : timeout ? ERR : COUNT;
            HI:       state_n = xfer ? LO : timeout ? ERR : HI;
            LO:       state_n = xfer ? WRITE : timeout ? ERR : LO;
            WRITE:    state_n = addr == words ? CHECK : HI;
            CHECK:    state_n = xfer ? (sum == 8'h00 ? RUN : ERR) : timeout ? ERR : CHECK;
            default:  state_n = RUN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= RUN;
            words   <= '0;
            addr    <= '0;
            acc     <= '0;
            ram_di  <= '0;
            idle    <= '0;
            load_ok <= 1'b0;
        end else begin
            state   <= state_n;
            load_ok <= state == CHECK && xfer && sum == 8'h00;
            idle    <= (waiting && !xfer) ? idle + 1'b1 : '0;
            if (start) begin
                acc  <= '0;
                addr <= '0;
            end
            if (xfer && state inside {COUNT, HI, LO}) acc <= sum;
            if (xfer && state == COUNT) words <= rx_data;
            if (xfer && state == HI) ram_di[15:8] <= rx_data;
            if (xfer && state == LO) ram_di[7:0] <= rx_data;
            if (state == WRITE && addr != words) addr <= addr + 8'd1;
        end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: table-driven and directed checks of the program loader
module tb_prog_mem_loader;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic reset_n;
    logic [7:0] rx_data, cpu_address, ram_address;
    logic rx_valid, rx_ready, ram_we, cpu_reset, load_busy, load_ok, load_err;
    logic [15:0] ram_di;
    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    bit mon_en = 1'b0;

    prog_mem_loader #(.START_BYTE(8'h5A), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .cpu_address(cpu_address), .ram_address(ram_address),
        .ram_di(ram_di), .ram_we(ram_we), .cpu_reset(cpu_reset), .load_busy(load_busy),
        .load_ok(load_ok), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v;
        logic [7:0] d, cpu, ra;
        logic rdy, we, cr, busy, ok, err;
        logic [15:0] di;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [7:0] cpu, input logic rdy,
                       input logic we, input logic [7:0] ra, input logic [15:0] di, input logic cr,
                       input logic busy, input logic ok, input logic err);
        vec_t r;
        r.v = v; r.d = d; r.cpu = cpu; r.rdy = rdy; r.we = we; r.ra = ra; r.di = di;
        r.cr = cr; r.busy = busy; r.ok = ok; r.err = err;
        tbl.push_back(r);
    endtask

    // Two-word load 01,0A,00,02,AA,c starting in RUN (fe=0) or ERR (fe=1) with ram_di=d0
    task automatic add_load(input logic [15:0] d0, input logic fe, input logic [7:0] c);
        add(1, 8'h5A, 8'h33, 1, 0, 8'h33, d0, fe, 0, 0, fe);
        add(1, 8'h01, 8'h33, 1, 0, 8'h00, d0, 1, 1, 0, 0);
        add(1, 8'h0A, 8'h33, 1, 0, 8'h00, d0, 1, 1, 0, 0);
        add(1, 8'h00, 8'h33, 1, 0, 8'h00, {8'h0A, d0[7:0]}, 1, 1, 0, 0);
        add(1, 8'h02, 8'h33, 0, 1, 8'h00, 16'h0A00, 1, 1, 0, 0);
        add(1, 8'h02, 8'h33, 1, 0, 8'h01, 16'h0A00, 1, 1, 0, 0);
        add(1, 8'hAA, 8'h33, 1, 0, 8'h01, 16'h0200, 1, 1, 0, 0);
        add(1, c, 8'h33, 0, 1, 8'h01, 16'h02AA, 1, 1, 0, 0);
        add(1, c, 8'h33, 1, 0, 8'h01, 16'h02AA, 1, 1, 0, 0);
    endtask

    task automatic send(input logic [7:0] b);
        bit done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data = b;
            if (rx_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send byte=%h rx_ready stayed low", b);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_rdy"}, 16'(rx_ready), 16'd1);
        chk({nm, "_we"}, 16'(ram_we), 16'd0);
        chk({nm, "_cr"}, 16'(cpu_reset), 16'd0);
        chk({nm, "_busy"}, 16'(load_busy), 16'd0);
        chk({nm, "_ok"}, 16'(load_ok), 16'd0);
        chk({nm, "_err"}, 16'(load_err), 16'd0);
        chk({nm, "_di"}, ram_di, 16'h0000);
        chk({nm, "_ra"}, 16'(ram_address), 16'(cpu_address));
    endtask

    always @(negedge clk) begin
        if (mon_en && ram_we) begin
            chk("full_wr_addr", 16'(ram_address), 16'(wr_cnt[7:0]));
            chk("full_wr_data", ram_di, {wr_cnt[7:0], wr_cnt[7:0]});
            wr_cnt++;
        end
    end

    initial begin
        logic [7:0] s;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        cpu_address = 8'h00;
        reset_n = 1'b0;
        add_load(16'h0000, 0, 8'h49);
        add(0, 8'h00, 8'h44, 1, 0, 8'h44, 16'h02AA, 0, 0, 1, 0);
        add(0, 8'h00, 8'h45, 1, 0, 8'h45, 16'h02AA, 0, 0, 0, 0);
        add_load(16'h02AA, 0, 8'h48);
        add(1, 8'h00, 8'h44, 1, 0, 8'h44, 16'h02AA, 1, 0, 0, 1);
        add_load(16'h02AA, 1, 8'h49);
        add(0, 8'h00, 8'h44, 1, 0, 8'h44, 16'h02AA, 0, 0, 1, 0);
        add(0, 8'h00, 8'h45, 1, 0, 8'h45, 16'h02AA, 0, 0, 0, 0);
        add(1, 8'h00, 8'h10, 1, 0, 8'h10, 16'h02AA, 0, 0, 0, 0);
        add(0, 8'hFF, 8'h11, 1, 0, 8'h11, 16'h02AA, 0, 0, 0, 0);
        add(1, 8'hFF, 8'h12, 1, 0, 8'h12, 16'h02AA, 0, 0, 0, 0);
        add(0, 8'hA5, 8'h13, 1, 0, 8'h13, 16'h02AA, 0, 0, 0, 0);
        add(1, 8'hA5, 8'h14, 1, 0, 8'h14, 16'h02AA, 0, 0, 0, 0);
        add(1, 8'h00, 8'h15, 1, 0, 8'h15, 16'h02AA, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cpu_address = 8'h33;
        #1;
        chk_reset("reset");
        reset_n = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk);
            rx_valid = tbl[i].v;
            rx_data = tbl[i].d;
            cpu_address = tbl[i].cpu;
            #1;
            chk($sformatf("row%0d_rdy", i), 16'(rx_ready), 16'(tbl[i].rdy));
            chk($sformatf("row%0d_we", i), 16'(ram_we), 16'(tbl[i].we));
            chk($sformatf("row%0d_ra", i), 16'(ram_address), 16'(tbl[i].ra));
            chk($sformatf("row%0d_di", i), ram_di, tbl[i].di);
            chk($sformatf("row%0d_cr", i), 16'(cpu_reset), 16'(tbl[i].cr));
            chk($sformatf("row%0d_busy", i), 16'(load_busy), 16'(tbl[i].busy));
            chk($sformatf("row%0d_ok", i), 16'(load_ok), 16'(tbl[i].ok));
            chk($sformatf("row%0d_err", i), 16'(load_err), 16'(tbl[i].err));
        end
        // timeout: TO-1 idle cycles leave the load alive, the TO-th one aborts it
        send(8'h5A); send(8'h01); send(8'h0A);
        rx_valid = 1'b0;
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        chk("to_early_err", 16'(load_err), 16'd0);
        chk("to_early_busy", 16'(load_busy), 16'd1);
        @(negedge clk);
        chk("to_err", 16'(load_err), 16'd1);
        chk("to_cr", 16'(cpu_reset), 16'd1);
        chk("to_busy", 16'(load_busy), 16'd0);
        send(8'h5A); send(8'h01); send(8'h0A);
        rx_valid = 1'b0;
        repeat (TO - 1) @(posedge clk);
        send(8'h00);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("late_byte_err", 16'(load_err), 16'd0);
        chk("late_byte_we", 16'(ram_we), 16'd1);
        @(negedge clk);
        chk("mid_hi_busy", 16'(load_busy), 16'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset("mid_reset");
        reset_n = 1'b1;
        send(8'h01);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_cr", 16'(cpu_reset), 16'd0);
        chk("post_reset_busy", 16'(load_busy), 16'd0);
        chk("post_reset_ra", 16'(ram_address), 16'(cpu_address));
        // full 256-word image, word i = {i,i}
        mon_en = 1'b1;
        send(8'h5A);
        send(8'hFF);
        s = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            send(8'(i));
            s = s + 8'(i) + 8'(i);
        end
        send(8'h00 - s);
        rx_valid = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        chk("full_ok", 16'(load_ok), 16'd1);
        chk("full_cr", 16'(cpu_reset), 16'd0);
        chk("full_err", 16'(load_err), 16'd0);
        chk("full_writes", 16'(wr_cnt), 16'd256);
        @(negedge clk);
        chk("full_ok_pulse", 16'(load_ok), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
